// File: rtl/cpu_pkg.sv
// Shared types and helpers for the 8-bit CPU datapath blocks.
// Holds the PCH fix-up state encoding and the PCL-carry step rule.
package cpu_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [0:0] {FIX_IDLE, FIX_ADJ} pch_fix_state_t;

    // Conflicting increment/decrement qualifiers cancel to no step.
    function automatic logic signed [2:0] step_term(
        input logic inc,
        input logic dec,
        input logic en
    );
        step_term = 3'sb000;
        if (en && inc && !dec) begin
            step_term = 3'sb001;
        end else if (en && dec && !inc) begin
            step_term = 3'sb111;
        end
    endfunction

endpackage

// File: rtl/pch_incdec.sv
// Combinational modulo-256 adder for the PCH byte.
// Applies a small signed delta (-2..+2) with natural wrap.
module pch_incdec
    import cpu_pkg::*;
(
    input  logic [BUS_W-1:0]  value_i,
    input  logic signed [2:0] delta_i,
    output logic [BUS_W-1:0]  value_o
);

    logic [BUS_W-1:0] delta_ext;

    assign delta_ext = {{(BUS_W-3){delta_i[2]}}, delta_i};
    assign value_o   = value_i + delta_ext;

endmodule

// File: rtl/program_counter_high.sv
// Program-counter high byte: steps on the PCL carry/borrow, loads from ADH,
// drives DB/ADH, and applies a deferred +/-1 after a page-crossing branch.
module program_counter_high
    import cpu_pkg::*;
#(
    parameter logic [BUS_W-1:0] RESET_VAL = 8'h00,
    parameter logic [BUS_W-1:0] IDLE_BUS  = 8'h00
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [BUS_W-1:0] ADH_in,
    input  logic             ADH_PCH,
    input  logic             PCH_PCH,
    input  logic             PCH_DB,
    input  logic             PCH_ADH,
    input  logic             PCLC,
    input  logic             increment,
    input  logic             decrement,
    input  logic             fix_req,
    input  logic             fix_dir,
    output logic [BUS_W-1:0] DB_out,
    output logic [BUS_W-1:0] ADH_out,
    output logic             fix_busy,
    output logic             fix_done
);

    logic [BUS_W-1:0] pch_q, pch_d;
    pch_fix_state_t   state_q, state_d;
    logic             fix_dir_q, fix_dir_d;
    logic             fix_done_q, fix_done_d;

    logic signed [2:0] step_delta;
    logic signed [2:0] fix_delta;
    logic signed [2:0] delta;
    logic [BUS_W-1:0]  pch_sum;

    assign step_delta = step_term(increment, decrement, PCH_PCH & PCLC);
    assign fix_delta  = (state_q == FIX_ADJ) ? (fix_dir_q ? 3'sb111 : 3'sb001) : 3'sb000;
    // Both terms are within -1..+1, so the 3-bit sum never overflows.
    assign delta      = step_delta + fix_delta;

    pch_incdec u_incdec (
        .value_i (pch_q),
        .delta_i (delta),
        .value_o (pch_sum)
    );

    always_comb begin
        pch_d = pch_q;
        if (ADH_PCH) begin
            pch_d = ADH_in;
        end else if (PCH_PCH || (state_q == FIX_ADJ)) begin
            pch_d = pch_sum;
        end
    end

    always_comb begin
        state_d    = state_q;
        fix_dir_d  = fix_dir_q;
        fix_done_d = 1'b0;
        case (state_q)
            FIX_IDLE: begin
                if (fix_req) begin
                    state_d   = FIX_ADJ;
                    fix_dir_d = fix_dir;
                end
            end
            FIX_ADJ: begin
                state_d    = FIX_IDLE;
                // A same-cycle load overrides the fix, so nothing was applied.
                fix_done_d = !ADH_PCH;
            end
            default: state_d = FIX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pch_q      <= RESET_VAL;
            state_q    <= FIX_IDLE;
            fix_dir_q  <= 1'b0;
            fix_done_q <= 1'b0;
        end else begin
            pch_q      <= pch_d;
            state_q    <= state_d;
            fix_dir_q  <= fix_dir_d;
            fix_done_q <= fix_done_d;
        end
    end

    assign DB_out   = PCH_DB  ? pch_q : IDLE_BUS;
    assign ADH_out  = PCH_ADH ? pch_q : IDLE_BUS;
    assign fix_busy = (state_q == FIX_ADJ);
    assign fix_done = fix_done_q;

endmodule

// File: tb/tb_program_counter_high.sv
// Self-checking bench for program_counter_high: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_program_counter_high;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] ADH_in;
    logic       ADH_PCH, PCH_PCH, PCH_DB, PCH_ADH, PCLC;
    logic       increment, decrement, fix_req, fix_dir;
    logic [7:0] DB_out, ADH_out;
    logic       fix_busy, fix_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: PCH as an integer, a pending-fix flag and the done flag.
    int m_pch;
    bit m_adj;
    bit m_dir;
    bit m_done;

    localparam logic [7:0] IDLE = 8'h00;

    program_counter_high #(
        .RESET_VAL (8'h00),
        .IDLE_BUS  (8'h00)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ADH_in    (ADH_in),
        .ADH_PCH   (ADH_PCH),
        .PCH_PCH   (PCH_PCH),
        .PCH_DB    (PCH_DB),
        .PCH_ADH   (PCH_ADH),
        .PCLC      (PCLC),
        .increment (increment),
        .decrement (decrement),
        .fix_req   (fix_req),
        .fix_dir   (fix_dir),
        .DB_out    (DB_out),
        .ADH_out   (ADH_out),
        .fix_busy  (fix_busy),
        .fix_done  (fix_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ADH_in = 8'h00; ADH_PCH = 0; PCH_PCH = 0; PCLC = 0;
        increment = 0; decrement = 0; fix_req = 0; fix_dir = 0;
    endtask

    task automatic model_reset();
        m_pch = 0; m_adj = 0; m_dir = 0; m_done = 0;
    endtask

    task automatic model_edge();
        int step, fixd;
        step = 0;
        if (PCH_PCH && PCLC && (increment != decrement)) step = increment ? 1 : -1;
        fixd = m_adj ? (m_dir ? -1 : 1) : 0;
        if (ADH_PCH) m_pch = ADH_in;
        else         m_pch = (m_pch + step + fixd + 256) % 256;
        m_done = m_adj && !ADH_PCH;
        if (m_adj) m_adj = 0;
        else if (fix_req) begin
            m_adj = 1;
            m_dir = fix_dir;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".db"},   DB_out,   PCH_DB  ? 8'(m_pch) : IDLE);
        check({tag, ".adh"},  ADH_out,  PCH_ADH ? 8'(m_pch) : IDLE);
        check({tag, ".busy"}, {7'd0, fix_busy}, {7'd0, m_adj});
        check({tag, ".done"}, {7'd0, fix_done}, {7'd0, m_done});
    endtask

    // One clock: DUT and model take the same edge, outputs compared on the falling edge.
    task automatic step_cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic load(input logic [7:0] v);
        ADH_in = v; ADH_PCH = 1;
        step_cycle("load");
        ADH_PCH = 0;
    endtask

    task automatic apply_reset();
        nrst = 0;
        #1;
        model_reset();
        check_model("rst");
        check("rst.busy0", {7'd0, fix_busy}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        nrst = 1;
    endtask

    initial begin
        clear_inputs();
        PCH_DB = 0; PCH_ADH = 0;
        nrst = 1;
        @(negedge clk);
        apply_reset();
        $display("txn reset: DB=%02h ADH=%02h busy=%0b", DB_out, ADH_out, fix_busy);

        // Load then drive onto ADH only.
        load(8'h12);
        PCH_ADH = 1;
        #1;
        check("load.adh", ADH_out, 8'h12);
        check("load.db_idle", DB_out, 8'h00);
        $display("txn load 12: ADH=%02h DB=%02h", ADH_out, DB_out);
        PCH_DB = 1;

        // Increment wrap, then no-carry hold.
        load(8'hFF);
        PCH_PCH = 1; increment = 1; PCLC = 1;
        step_cycle("inc");
        check("inc.wrap", DB_out, 8'h00);
        load(8'hFF);
        PCH_PCH = 1; increment = 1; PCLC = 0;
        step_cycle("inc0");
        check("inc.nocarry", DB_out, 8'hFF);
        $display("txn step inc: PCH=%02h", DB_out);

        // Decrement wrap, then conflicting qualifiers.
        clear_inputs();
        load(8'h00);
        PCH_PCH = 1; decrement = 1; PCLC = 1;
        step_cycle("dec");
        check("dec.wrap", DB_out, 8'hFF);
        increment = 1;
        step_cycle("both");
        check("both.hold", DB_out, 8'hFF);
        $display("txn step dec: PCH=%02h", DB_out);

        // Fix-up +1 with an ignored request during ADJ.
        clear_inputs();
        load(8'h34);
        fix_req = 1; fix_dir = 0;
        step_cycle("fixN");
        check("fix.busy", {7'd0, fix_busy}, 8'h01);
        fix_req = 1; fix_dir = 1;
        step_cycle("fixN1");
        fix_req = 0;
        check("fix.pch", DB_out, 8'h35);
        check("fix.done", {7'd0, fix_done}, 8'h01);
        check("fix.idle", {7'd0, fix_busy}, 8'h00);
        step_cycle("fixN2");
        check("fix.done_low", {7'd0, fix_done}, 8'h00);
        check("fix.no_requeue", DB_out, 8'h35);
        $display("txn fix +1: PCH=%02h", DB_out);

        // Fix-up combined with a same-cycle carry step.
        load(8'hFF);
        fix_req = 1; fix_dir = 0;
        step_cycle("fs0");
        fix_req = 0; PCH_PCH = 1; increment = 1; PCLC = 1;
        step_cycle("fs1");
        check("fixstep.pch", DB_out, 8'h01);
        $display("txn fix+step: PCH=%02h", DB_out);

        // Load during ADJ cancels the fix.
        clear_inputs();
        load(8'h50);
        fix_req = 1; fix_dir = 1;
        step_cycle("c0");
        fix_req = 0; ADH_PCH = 1; ADH_in = 8'hA0;
        step_cycle("c1");
        ADH_PCH = 0;
        check("cancel.pch", DB_out, 8'hA0);
        check("cancel.nodone", {7'd0, fix_done}, 8'h00);
        step_cycle("c2");
        check("cancel.nodone2", {7'd0, fix_done}, 8'h00);
        $display("txn fix cancel: PCH=%02h", DB_out);

        // Asynchronous reset in the middle of a fix.
        load(8'h77);
        fix_req = 1;
        step_cycle("r0");
        fix_req = 0;
        check("midrst.busy_before", {7'd0, fix_busy}, 8'h01);
        apply_reset();
        step_cycle("r1");
        check("midrst.pch", DB_out, 8'h00);
        check("midrst.nodone", {7'd0, fix_done}, 8'h00);
        step_cycle("r2");
        $display("txn mid-fix reset: PCH=%02h busy=%0b", DB_out, fix_busy);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ADH_in    = 8'($urandom);
            ADH_PCH   = ($urandom_range(0, 7) == 0);
            PCH_PCH   = 1'($urandom);
            PCLC      = 1'($urandom);
            increment = 1'($urandom);
            decrement = 1'($urandom);
            fix_req   = ($urandom_range(0, 2) == 0);
            fix_dir   = 1'($urandom);
            PCH_DB    = 1'($urandom);
            PCH_ADH   = 1'($urandom);
            if ($urandom_range(0, 79) == 0) apply_reset();
            else step_cycle("rand");
        end
        $display("txn random: 600 cycles");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_counter_high.md
# program_counter_high

Program-counter high byte (PCH) for the 8-bit CPU datapath. Consumes the PCL carry/borrow flag (PCLC) to step the upper address byte. Loads from and drives the ADH and DB buses. Contains a one-cycle fix-up sequencer that adds a deferred ±1 to PCH after a relative branch crosses a page.

## Interface
Parameters:
- RESET_VAL, 8'h00, PCH value on reset
- IDLE_BUS, 8'h00, value driven on DB_out/ADH_out when not enabled

Ports:
- clk  input  1  clock
- nrst  input  1  reset, asynchronous, active-low
- ADH_in  input  8  address bus high input
- ADH_PCH  input  1  load PCH from ADH_in
- PCH_PCH  input  1  recirculate PCH through inc/dec logic
- PCH_DB  input  1  drive PCH on DB_out
- PCH_ADH  input  1  drive PCH on ADH_out
- PCLC  input  1  carry (increment) or borrow (decrement) out of PCL, same cycle
- increment, decrement  input  1 each  step direction qualifiers for PCLC
- fix_req  input  1  request a branch page fix-up
- fix_dir  input  1  fix-up direction: 0 = +1, 1 = −1; sampled with fix_req
- DB_out, ADH_out  output  8 each  bus drives
- fix_busy  output  1  fix-up sequencer in ADJ state
- fix_done  output  1  one-cycle pulse after the fix-up is applied

## Operation
- Register update priority at each clk edge:
  - ADH_PCH: PCH ← ADH_in. Any step and any fix-up delta in that cycle are discarded.
  - else PCH_PCH or state ADJ: PCH ← PCH + delta (mod 256).
  - else: hold.
- Step term:
  - +1 if increment & PCLC & PCH_PCH.
  - −1 if decrement & PCLC & PCH_PCH.
  - 0 if increment and decrement are both high.
- Fix term: +1 or −1 per the latched direction, only while in ADJ.
- delta = step term + fix term, range −2..+2. Wrap: FF+1=00, 00−1=FF, FF+2=01, 01−2=FF.
- Bus outputs are combinational from the current PCH register:
  - DB_out = PCH_DB ? PCH : IDLE_BUS.
  - ADH_out = PCH_ADH ? PCH : IDLE_BUS.
- Fix-up FSM, states FIX_IDLE and FIX_ADJ:
  - FIX_IDLE → FIX_ADJ when fix_req=1. fix_dir is latched into fix_dir_q.
  - FIX_ADJ → FIX_IDLE unconditionally after one cycle. The fix delta is applied at that edge.
  - fix_req while in FIX_ADJ is ignored and not queued.
  - ADH_PCH during FIX_ADJ cancels the fix: the load wins, the FSM still returns to IDLE, and fix_done is NOT pulsed.
- fix_busy = (state == FIX_ADJ).
- fix_done is a registered flag. It is set at the FIX_ADJ→IDLE edge when the fix was applied, so it is high for the following cycle only.

## Timing
- Reset (nrst low, asynchronous): PCH=RESET_VAL, state=FIX_IDLE, fix_dir_q=0, fix_done=0.
- During reset: fix_busy=0, and DB_out/ADH_out reflect their enables against PCH=RESET_VAL.
- Reset in mid-fix: the FSM aborts to IDLE immediately and no fix_done pulse follows.
- Step latency: PCLC and the qualifiers are sampled in cycle N. The new PCH is visible on the buses in cycle N+1.
- Fix-up sequence:
  - fix_req high in cycle N.
  - fix_busy high in N+1.
  - PCH adjusted at the end of N+1.
  - fix_done high in N+2.
- Back-to-back: a fix_req in cycle N+2 is accepted (the FSM is IDLE in N+2).
- Load latency: ADH_in captured at edge end of N, visible in N+1.

## Structure
- Package cpu_pkg holds:
  - typedef enum logic [0:0] {FIX_IDLE, FIX_ADJ} pch_fix_state_t;
  - localparam BUS_W = 8.
- Sub-module pch_incdec (combinational):
  - inputs: 8-bit value, signed 3-bit delta.
  - output: 8-bit value + delta mod 256.
- Top level holds the PCH register, the FSM, the fix_dir_q and fix_done flops, and the bus drive logic.

## Test plan
- Reset, then drive ADH_in=8'h12, ADH_PCH=1 for one cycle, then PCH_ADH=1 → ADH_out=8'h12 next cycle; DB_out=8'h00.
- PCH=8'hFF, PCH_PCH=1, increment=1, PCLC=1 → PCH=8'h00 next cycle. The same stimulus with PCLC=0 → PCH stays 8'hFF.
- PCH=8'h00, decrement=1, PCLC=1, PCH_PCH=1 → 8'hFF. With increment and decrement both high → PCH unchanged.
- PCH=8'h34, fix_req=1, fix_dir=0 in cycle N:
  - fix_busy=1 in N+1.
  - PCH=8'h35 and fix_done=1 in N+2.
  - fix_done=0 in N+3.
  - fix_req in N+1 has no effect.
- PCH=8'hFF, fix in FIX_ADJ with fix_dir=0, plus PCLC=1 step → PCH=8'h01.
- Fix cancel and mid-fix reset:
  - Fix in FIX_ADJ with ADH_PCH=1, ADH_in=8'hA0 → PCH=8'hA0 and no fix_done.
  - A separate run with nrst pulsed low during FIX_ADJ → PCH=8'h00, fix_busy=0, and no fix_done afterwards.
